// File: rtl/logic_unit_acc.sv
// Bitwise logic unit with an element mode and a left-to-right reduction (accumulate) mode.
// Valid/ready on both sides. The registered result holds while the consumer stalls.
module logic_unit_acc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             last,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic [CNT_W-1:0] beats
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [2:0]       op_reg, op_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             out_zero_reg, out_zero_next;
  logic [CNT_W-1:0] beats_reg, beats_next;

  logic             accept;
  logic             load;
  logic [3:0]       elem_lut;
  logic [3:0]       acc_lut;
  logic [WIDTH-1:0] elem_res;
  logic [WIDTH-1:0] acc_res;
  logic [CNT_W-1:0] count_inc;

  // Each op is a 2-input truth table indexed by {a, b}; bit k is the result for {a,b} == k.
  function automatic logic [3:0] op_lut(input logic [2:0] code);
    logic [3:0] t;
    case (code)
      3'b000:  t = 4'b1000; // AND
      3'b001:  t = 4'b1110; // OR
      3'b010:  t = 4'b0110; // XOR
      3'b011:  t = 4'b0001; // NOR
      3'b100:  t = 4'b0111; // NAND
      3'b101:  t = 4'b1001; // XNOR
      3'b110:  t = 4'b0100; // a & ~b
      default: t = 4'b1100; // pass a
    endcase
    return t;
  endfunction

  assign elem_lut = op_lut(op);
  assign acc_lut  = op_lut(op_reg);

  // The running value is always the left operand, which keeps non-associative ops in arrival order.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign elem_res[gi] = elem_lut[{in1[gi], in2[gi]}];
      assign acc_res[gi]  = acc_lut[{acc_reg[gi], in1[gi]}];
    end
  endgenerate

  assign in_ready  = !out_valid_reg || out_ready;
  assign accept    = in_valid && in_ready;
  assign count_inc = (count_reg == {CNT_W{1'b1}}) ? count_reg : count_reg + CNT_W'(1);

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    acc_next   = acc_reg;
    count_next = count_reg;
    out_next   = out_reg;
    beats_next = beats_reg;
    load       = 1'b0;

    if (accept) begin
      if (state_reg == ACC) begin
        // Inside a burst the live op and acc_mode are ignored.
        if (last) begin
          load       = 1'b1;
          out_next   = acc_res;
          beats_next = count_inc;
          state_next = IDLE;
          acc_next   = '0;
          count_next = '0;
        end else begin
          acc_next   = acc_res;
          count_next = count_inc;
        end
      end else if (!acc_mode) begin
        load       = 1'b1;
        out_next   = elem_res;
        beats_next = CNT_W'(1);
      end else if (last) begin
        load       = 1'b1;
        out_next   = in1;
        beats_next = CNT_W'(1);
      end else begin
        state_next = ACC;
        op_next    = op;
        acc_next   = in1;
        count_next = CNT_W'(1);
      end
    end

    if (load) begin
      out_valid_next = 1'b1;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end else begin
      out_valid_next = out_valid_reg;
    end
    out_zero_next = load ? (out_next == '0) : out_zero_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      op_reg        <= 3'b000;
      acc_reg       <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      out_zero_reg  <= 1'b1;
      beats_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      acc_reg       <= acc_next;
      count_reg     <= count_next;
      out_valid_reg <= out_valid_next;
      out_reg       <= out_next;
      out_zero_reg  <= out_zero_next;
      beats_reg     <= beats_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign out_zero  = out_zero_reg;
  assign beats     = beats_reg;

endmodule

// File: tb/tb_logic_unit_acc.sv
// Random and directed checks of logic_unit_acc against a burst-level reference model.
// Two instances share stimulus; the second has a 2-bit beat counter to exercise saturation.
module tb_logic_unit_acc;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [2:0]   op = 3'b000;
  logic         acc_mode = 1'b0;
  logic         last = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         out_ready = 1'b0;

  logic         in_ready, out_valid, out_zero;
  logic [W-1:0] out;
  logic [7:0]   beats;
  logic         in_ready2, out_valid2, out_zero2;
  logic [W-1:0] out2;
  logic [1:0]   beats2;

  logic_unit_acc #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .acc_mode(acc_mode), .last(last), .in1(in1), .in2(in2), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .out_zero(out_zero), .beats(beats)
  );

  logic_unit_acc #(.WIDTH(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .op(op),
    .acc_mode(acc_mode), .last(last), .in1(in1), .in2(in2), .out_valid(out_valid2),
    .out_ready(out_ready), .out(out2), .out_zero(out_zero2), .beats(beats2)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: expected output register plus the list of beats of the open burst.
  bit           exp_valid;
  logic [W-1:0] exp_out;
  int           exp_n;
  bit           open;
  logic [2:0]   bop;
  logic [W-1:0] bq[$];

  function automatic logic [W-1:0] f(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return ~(a & b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a;
    endcase
  endfunction

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic model_accept(input logic [2:0] o, input bit m, input bit l,
                              input logic [W-1:0] a, input logic [W-1:0] b, output bit ld);
    logic [W-1:0] r;
    ld = 1'b0;
    if (!open && !m) begin
      ld = 1'b1; exp_out = f(o, a, b); exp_n = 1;
    end else if (!open) begin
      if (l) begin
        ld = 1'b1; exp_out = a; exp_n = 1;
      end else begin
        open = 1'b1; bop = o; bq.delete(); bq.push_back(a);
      end
    end else begin
      bq.push_back(a);
      if (l) begin
        r = bq[0];
        for (int i = 1; i < bq.size(); i++) r = f(bop, r, bq[i]);
        ld = 1'b1; exp_out = r; exp_n = bq.size();
        open = 1'b0; bq.delete();
      end
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model, check outputs after the edge.
  task automatic step(input bit v, input logic [2:0] o, input bit m, input bit l,
                      input logic [W-1:0] a, input logic [W-1:0] b, input bit r);
    bit rdy, ld;
    in_valid = v; op = o; acc_mode = m; last = l; in1 = a; in2 = b; out_ready = r;
    #1;
    rdy = !exp_valid || r;
    nvec++;
    if (in_ready !== rdy || in_ready2 !== rdy) begin
      nerr++;
      $display("FAIL in_ready: got %b/%b exp %b", in_ready, in_ready2, rdy);
    end
    @(posedge clk);
    ld = 1'b0;
    if (v && rdy) model_accept(o, m, l, a, b, ld);
    if (ld) exp_valid = 1'b1;
    else if (r) exp_valid = 1'b0;
    #1;
    nvec++;
    if (out_valid !== exp_valid || out_valid2 !== exp_valid) begin
      nerr++;
      $display("FAIL out_valid: got %b/%b exp %b", out_valid, out_valid2, exp_valid);
    end
    if (exp_valid) begin
      nvec++;
      if (out !== exp_out || out2 !== exp_out) begin
        nerr++;
        $display("FAIL out: got %h/%h exp %h", out, out2, exp_out);
      end
      nvec++;
      if (out_zero !== (exp_out == '0) || out_zero2 !== (exp_out == '0)) begin
        nerr++;
        $display("FAIL out_zero: got %b/%b exp %b", out_zero, out_zero2, exp_out == '0);
      end
      nvec++;
      if (int'(beats) != sat(exp_n, 255) || int'(beats2) != sat(exp_n, 3)) begin
        nerr++;
        $display("FAIL beats: got %0d/%0d exp %0d/%0d", beats, beats2, sat(exp_n, 255), sat(exp_n, 3));
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; acc_mode = 1'b1; last = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    exp_valid = 1'b0; exp_out = '0; exp_n = 0; open = 1'b0; bq.delete();
    nvec++;
    if (out_valid !== 1'b0 || out !== '0 || out_zero !== 1'b1 || beats !== 8'd0) begin
      nerr++;
      $display("FAIL reset: got v=%b out=%h z=%b beats=%0d exp v=0 out=0 z=1 beats=0",
               out_valid, out, out_zero, beats);
    end
    nvec++;
    if (out_valid2 !== 1'b0 || out2 !== '0 || out_zero2 !== 1'b1 || beats2 !== 2'd0) begin
      nerr++;
      $display("FAIL reset2: got v=%b out=%h z=%b beats=%0d exp v=0 out=0 z=1 beats=0",
               out_valid2, out2, out_zero2, beats2);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    in_valid = 1'b0;
    #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL ready_after_reset: got %b exp 1", in_ready);
    end
  endtask

  task automatic test_element();
    step(1, 3'b001, 0, 0, 32'h0000A5A5, 32'h00005A5A, 1);
    nvec++;
    if (out !== 32'h0000FFFF || beats !== 8'd1 || out_zero !== 1'b0) begin
      nerr++;
      $display("FAIL elem_or: got %h beats=%0d z=%b exp 0000ffff beats=1 z=0", out, beats, out_zero);
    end
    step(1, 3'b010, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1);
    nvec++;
    if (out !== '0 || out_zero !== 1'b1) begin
      nerr++;
      $display("FAIL elem_xor_eq: got %h z=%b exp 0 z=1", out, out_zero);
    end
    step(1, 3'b011, 0, 0, '0, '0, 1);
    nvec++;
    if (out !== 32'hFFFFFFFF) begin
      nerr++;
      $display("FAIL elem_nor_zero: got %h exp ffffffff", out);
    end
    for (int o = 0; o < 8; o++) step(1, 3'(o), 0, 0, $urandom, $urandom, 1);
  endtask

  task automatic test_backpressure();
    step(1, 3'b000, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0);
    for (int i = 0; i < 3; i++) step(1, 3'b001, 0, 0, 32'h11110000, 32'h00002222, 0);
    step(1, 3'b001, 0, 0, 32'h11110000, 32'h00002222, 1);
    nvec++;
    if (out !== 32'h11112222 || out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL bp_release: got %h v=%b exp 11112222 v=1", out, out_valid);
    end
    step(0, 3'b000, 0, 0, '0, '0, 1);
  endtask

  task automatic test_accumulate();
    step(1, 3'b001, 1, 0, 32'd1, $urandom, 1);
    step(1, 3'b000, 0, 0, 32'd2, $urandom, 1);
    step(1, 3'b100, 1, 0, 32'd4, $urandom, 1);
    step(1, 3'b010, 0, 1, 32'd8, $urandom, 1);
    nvec++;
    if (out !== 32'h0000000F || beats !== 8'd4) begin
      nerr++;
      $display("FAIL acc_or: got %h beats=%0d exp 0000000f beats=4", out, beats);
    end
    step(1, 3'b000, 1, 1, 32'h12345678, $urandom, 1);
    nvec++;
    if (out !== 32'h12345678 || beats !== 8'd1) begin
      nerr++;
      $display("FAIL acc_single: got %h beats=%0d exp 12345678 beats=1", out, beats);
    end
    // An element beat right after proves the single-beat burst left the block idle.
    step(1, 3'b110, 0, 0, 32'hFFFF0000, 32'h0FF00FF0, 1);
    // NOR burst: ~(~(a|b)|c) differs from ~(a|~(b|c)), so ordering matters.
    step(1, 3'b011, 1, 0, 32'h0000000C, '0, 1);
    step(1, 3'b011, 1, 0, 32'h0000000A, '0, 1);
    step(1, 3'b011, 1, 1, 32'h00000001, '0, 1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) step(1, 3'b010, 1, (i == 4), 32'd1, '0, 1);
    nvec++;
    if (beats2 !== 2'd3 || out2 !== 32'd1 || beats !== 8'd5) begin
      nerr++;
      $display("FAIL sat: got beats2=%0d out2=%h beats=%0d exp 3 1 5", beats2, out2, beats);
    end
    step(1, 3'b010, 1, 0, 32'hFF, '0, 1);
    step(1, 3'b010, 1, 0, 32'h0F, '0, 1);
    do_reset();
    step(1, 3'b001, 1, 0, 32'd3, '0, 1);
    step(1, 3'b000, 1, 1, 32'd4, '0, 1);
    nvec++;
    if (out !== 32'd7 || beats !== 8'd2 || beats2 !== 2'd2) begin
      nerr++;
      $display("FAIL post_reset_burst: got %h beats=%0d/%0d exp 7 beats=2/2", out, beats, beats2);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) step(1, 3'($urandom_range(0, 7)), 0, 0, $urandom, $urandom, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
           $urandom_range(0, 4) == 0, $urandom, $urandom, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 4; i++) step(0, 3'b000, 0, 0, '0, '0, 1);
  endtask

  initial begin
    exp_valid = 1'b0; exp_out = '0; exp_n = 0; open = 1'b0; bop = 3'b000;
    test_reset();
    test_element();
    test_backpressure();
    test_accumulate();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
